// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects RAW data hazards and mult/div busy conflicts,
// producing stall/flush controls plus a mult/div busy counter and a stall-cycle counter.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IDRs,
   input  logic [4:0]  IDRt,
   input  logic [1:0]  IDTuseRs,
   input  logic [1:0]  IDTuseRt,
   input  logic [4:0]  EXRegDst,
   input  logic [4:0]  MEMRegDst,
   input  logic        EXRegWriteEn,
   input  logic        MEMRegWriteEn,
   input  logic [31:0] EXTimeNew,
   input  logic [31:0] MEMTimeNew,
   input  logic        EXMDStart,
   input  logic        EXMDType,
   input  logic        IDIsMD,
   input  logic        IntReq,
   input  logic        IDIsEret,
   output logic        PCStall,
   output logic        IFIDStall,
   output logic        IFIDFlush,
   output logic        IDEXFlush,
   output logic        EXMEMFlush,
   output logic        MDBusy,
   output logic [3:0]  MDCount,
   output logic [31:0] StallCycles
);

   logic [3:0]  r_mdCount;
   logic [31:0] r_stallCycles;

   logic w_rsExHit, w_rsMemHit, w_rtExHit, w_rtMemHit;
   logic w_rsHazard, w_rtHazard;
   logic w_mdBusy, w_mdStall, w_stall;

   // Tuse is zero-extended so a huge remaining Tnew still counts as "not ready yet".
   assign w_rsExHit  = EXRegWriteEn  && (EXRegDst  == IDRs) && (EXTimeNew  > {30'd0, IDTuseRs});
   assign w_rsMemHit = MEMRegWriteEn && (MEMRegDst == IDRs) && (MEMTimeNew > {30'd0, IDTuseRs});
   assign w_rtExHit  = EXRegWriteEn  && (EXRegDst  == IDRt) && (EXTimeNew  > {30'd0, IDTuseRt});
   assign w_rtMemHit = MEMRegWriteEn && (MEMRegDst == IDRt) && (MEMTimeNew > {30'd0, IDTuseRt});

   assign w_rsHazard = (IDRs != 5'd0) && (IDTuseRs != 2'd3) && (w_rsExHit || w_rsMemHit);
   assign w_rtHazard = (IDRt != 5'd0) && (IDTuseRt != 2'd3) && (w_rtExHit || w_rtMemHit);

   assign w_mdBusy  = EXMDStart || (r_mdCount != 4'd0);
   assign w_mdStall = IDIsMD && w_mdBusy;
   assign w_stall   = (w_rsHazard || w_rtHazard || w_mdStall) && !IntReq;

   // An exception wins over everything; eret squashes its delay slot only when ID advances.
   assign PCStall     = w_stall;
   assign IFIDStall   = w_stall;
   assign IDEXFlush   = w_stall || IntReq;
   assign EXMEMFlush  = IntReq;
   assign IFIDFlush   = IntReq || (IDIsEret && !w_stall);
   assign MDBusy      = w_mdBusy;
   assign MDCount     = r_mdCount;
   assign StallCycles = r_stallCycles;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mdCount     <= 4'd0;
         r_stallCycles <= 32'd0;
      end else begin
         if (r_mdCount != 4'd0)
            r_mdCount <= r_mdCount - 4'd1;
         else if (EXMDStart && !IntReq)
            r_mdCount <= EXMDType ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
         if (w_stall && (r_stallCycles != 32'hFFFF_FFFF))
            r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus directed bench for hazard_ctrl against a behavioural reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  IDRs, IDRt, EXRegDst, MEMRegDst;
   logic [1:0]  IDTuseRs, IDTuseRt;
   logic        EXRegWriteEn, MEMRegWriteEn;
   logic [31:0] EXTimeNew, MEMTimeNew;
   logic        EXMDStart, EXMDType, IDIsMD, IntReq, IDIsEret;
   logic        PCStall, IFIDStall, IFIDFlush, IDEXFlush, EXMEMFlush, MDBusy;
   logic [3:0]  MDCount;
   logic [31:0] StallCycles;

   int assertCount = 0;
   int failCount   = 0;

   // Reference state: remaining mult/div busy time and number of stalled cycles.
   int      modelBusyLeft = 0;
   longint  modelStalls   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .IDRs(IDRs), .IDRt(IDRt), .IDTuseRs(IDTuseRs), .IDTuseRt(IDTuseRt),
      .EXRegDst(EXRegDst), .MEMRegDst(MEMRegDst),
      .EXRegWriteEn(EXRegWriteEn), .MEMRegWriteEn(MEMRegWriteEn),
      .EXTimeNew(EXTimeNew), .MEMTimeNew(MEMTimeNew),
      .EXMDStart(EXMDStart), .EXMDType(EXMDType), .IDIsMD(IDIsMD),
      .IntReq(IntReq), .IDIsEret(IDIsEret),
      .PCStall(PCStall), .IFIDStall(IFIDStall), .IFIDFlush(IFIDFlush),
      .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
      .MDBusy(MDBusy), .MDCount(MDCount), .StallCycles(StallCycles)
   );

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      assertCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // A source waits if some in-flight writer of it will not have its result ready in time.
   function automatic bit operandBlocked(input int src, input int tuse);
      longint need;
      bit exLate, memLate;
      if (src == 0 || tuse == 3) return 1'b0;
      need    = longint'(tuse);
      exLate  = EXRegWriteEn  && int'(EXRegDst)  == src && longint'(EXTimeNew)  > need;
      memLate = MEMRegWriteEn && int'(MEMRegDst) == src && longint'(MEMTimeNew) > need;
      return exLate || memLate;
   endfunction

   function automatic bit modelStall();
      bit unitBusy;
      unitBusy = EXMDStart || modelBusyLeft > 0;
      if (IntReq) return 1'b0;
      return operandBlocked(int'(IDRs), int'(IDTuseRs)) ||
             operandBlocked(int'(IDRt), int'(IDTuseRt)) ||
             (IDIsMD && unitBusy);
   endfunction

   task automatic clearInputs();
      reset = 0; IDRs = 0; IDRt = 0; IDTuseRs = 0; IDTuseRt = 0;
      EXRegDst = 0; MEMRegDst = 0; EXRegWriteEn = 0; MEMRegWriteEn = 0;
      EXTimeNew = 0; MEMTimeNew = 0; EXMDStart = 0; EXMDType = 0;
      IDIsMD = 0; IntReq = 0; IDIsEret = 0;
   endtask

   task automatic applyStimulus();
      int pick;
      clearInputs();
      reset         = ($urandom % 64) == 0;
      IDRs          = 5'($urandom % 4);
      IDRt          = 5'($urandom % 4);
      IDTuseRs      = 2'($urandom % 4);
      IDTuseRt      = 2'($urandom % 4);
      EXRegDst      = 5'($urandom % 4);
      MEMRegDst     = 5'($urandom % 4);
      EXRegWriteEn  = 1'($urandom % 2);
      MEMRegWriteEn = 1'($urandom % 2);
      pick          = int'($urandom % 8);
      EXTimeNew     = (pick == 7) ? 32'hFFFF_FFFF - ($urandom % 4) : 32'(pick % 4);
      MEMTimeNew    = 32'($urandom % 3);
      EXMDStart     = ($urandom % 6) == 0;
      EXMDType      = 1'($urandom % 2);
      IDIsMD        = ($urandom % 3) == 0;
      IntReq        = ($urandom % 10) == 0;
      IDIsEret      = ($urandom % 8) == 0;
   endtask

   // Checks one cycle against the model, then advances model and DUT across an edge.
   task automatic stepCycle();
      bit expStall;
      #1;
      expStall = modelStall();
      checkOutput("PCStall",     PCStall,    expStall);
      checkOutput("IFIDStall",   IFIDStall,  expStall);
      checkOutput("IDEXFlush",   IDEXFlush,  expStall || IntReq);
      checkOutput("EXMEMFlush",  EXMEMFlush, IntReq);
      checkOutput("IFIDFlush",   IFIDFlush,  IntReq || (IDIsEret && !expStall));
      checkOutput("MDBusy",      MDBusy,     EXMDStart || modelBusyLeft > 0);
      checkOutput("MDCount",     MDCount,    modelBusyLeft);
      checkOutput("StallCycles", StallCycles, modelStalls);
      if (reset) begin
         modelBusyLeft = 0;
         modelStalls   = 0;
      end else begin
         if (modelBusyLeft > 0)
            modelBusyLeft--;
         else if (EXMDStart && !IntReq)
            modelBusyLeft = EXMDType ? 10 : 5;
         if (expStall && modelStalls < 64'hFFFF_FFFF)
            modelStalls++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      longint base;
      clearInputs();
      reset = 1;
      @(negedge clk);
      stepCycle();
      stepCycle();
      clearInputs();
      stepCycle();
      checkOutput("reset_count", StallCycles, 0);

      // Load-use on $5: EX then MEM producer, then ready.
      base = longint'(StallCycles);
      clearInputs();
      IDRs = 5; IDTuseRs = 0;
      EXRegWriteEn = 1; EXRegDst = 5; EXTimeNew = 2;
      #1 checkOutput("lw_ex_stall", PCStall, 1);
      stepCycle();
      EXRegWriteEn = 0; MEMRegWriteEn = 1; MEMRegDst = 5; MEMTimeNew = 1;
      #1 checkOutput("lw_mem_stall", IDEXFlush, 1);
      stepCycle();
      MEMTimeNew = 0;
      #1 checkOutput("lw_ready", PCStall, 0);
      stepCycle();
      checkOutput("lw_stall_total", longint'(StallCycles) - base, 2);

      // $zero never creates a hazard.
      clearInputs();
      EXRegWriteEn = 1; EXRegDst = 0; EXTimeNew = 2;
      #1 checkOutput("zero_reg", PCStall, 0);
      stepCycle();

      // Div occupies the unit for ten cycles after its start edge.
      clearInputs();
      EXMDStart = 1; EXMDType = 1; IDIsMD = 1;
      for (int i = 0; i <= 11; i++) begin
         #1 checkOutput("div_stall", PCStall, i <= 10);
         stepCycle();
         EXMDStart = 0;
         if (i == 0) checkOutput("div_load", MDCount, 10);
      end
      checkOutput("div_done", MDCount, 0);

      // Exception overrides a hazard stall and does not count as stalled.
      base = longint'(StallCycles);
      clearInputs();
      IDRs = 3; IDTuseRs = 0; EXRegWriteEn = 1; EXRegDst = 3; EXTimeNew = 2; IntReq = 1;
      #1 checkOutput("int_pcstall", PCStall, 0);
      checkOutput("int_flush", {IFIDFlush, IDEXFlush, EXMEMFlush}, 3'b111);
      stepCycle();
      checkOutput("int_nocount", longint'(StallCycles) - base, 0);

      // Exception suppresses a start; reset clears a running count.
      clearInputs();
      EXMDStart = 1; IntReq = 1;
      stepCycle();
      checkOutput("int_noload", MDCount, 0);
      clearInputs();
      EXMDStart = 1;
      stepCycle();
      clearInputs();
      stepCycle();
      checkOutput("mult_at4", MDCount, 4);
      reset = 1;
      stepCycle();
      checkOutput("reset_midcount", MDCount, 0);

      for (int n = 0; n < 3000; n++) begin
         applyStimulus();
         stepCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
